dpll_loop_filter: RTL and testbench

Digital loop filter for the DPLL. It consumes the UP/DOWN flags (flagu, flagd) produced by the phase-frequency detector and converts them into a saturating control word for the DCO. The filter has a proportional path and an integral path. Alongside it sits a reversal-based lock detector. Flags arrive from the IN/FB clock domains and are resynchronised to CLK inside the block.

---
 rtl/dpll_pkg.sv | 22 ++
 rtl/dpll_loop_filter_if.sv | 27 ++
 rtl/dpll_flag_sync.sv | 32 +++
 rtl/dpll_loop_filter.sv | 153 +++++++++++++++
 tb/tb_dpll_loop_filter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL loop filter.
//   lock_state_e : lock detector state (ACQ, LOCKED)
//   dir_e        : direction of the most recent accepted phase event
//   *_DEF        : default sizing constants for the filter and its interface
package dpll_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_e;

  localparam int CW_WIDTH_DEF  = 10;
  localparam int FRAC_BITS_DEF = 4;
  localparam int CW_INIT_DEF   = 512;

endpackage

// File: rtl/dpll_loop_filter_if.sv
// Signal bundle between the phase detector / DCO side and the loop filter.
//   flagu, flagd : UP/DOWN flags from the PFD (asynchronous to the filter clock)
//   HOLD         : freeze the loop (holdover)
//   ctrl         : DCO control word
//   locked       : lock indication
//   sat          : integrator sitting at its lower or upper bound
// master = PFD/DCO side, slave = loop filter.
interface dpll_loop_filter_if #(
  parameter int CW_WIDTH = dpll_pkg::CW_WIDTH_DEF
);
  logic                flagu;
  logic                flagd;
  logic                HOLD;
  logic [CW_WIDTH-1:0] ctrl;
  logic                locked;
  logic                sat;

  modport master (
    output flagu, flagd, HOLD,
    input  ctrl, locked, sat
  );

  modport slave (
    input  flagu, flagd, HOLD,
    output ctrl, locked, sat
  );
endinterface

// File: rtl/dpll_flag_sync.sv
// Two-flop synchroniser plus delay flop and rising-edge detector for one PFD
// flag. A level held high produces exactly one single-cycle event.
//   clk    : filter clock
//   rst    : asynchronous active-high reset
//   flag_i : asynchronous flag input
//   evt_o  : one-cycle pulse on a synchronised rising edge
module dpll_flag_sync (
  input  logic clk,
  input  logic rst,
  input  logic flag_i,
  output logic evt_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= flag_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign evt_o = sync_q & ~dly_q;

endmodule

// File: rtl/dpll_loop_filter.sv
// DPLL loop filter: turns PFD UP/DOWN flags into a saturating DCO control
// word using a proportional kick (one cycle per event) on top of an integral
// path, and runs a reversal-counting lock detector.
//   CLK   : filter clock, all state on rising edge
//   RESET : asynchronous active-high reset
//   bus   : slave side of dpll_loop_filter_if (flagu/flagd/HOLD in,
//           ctrl/locked/sat out, all outputs registered)
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter int CW_WIDTH   = CW_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int KP         = 4,
  parameter int KI         = 1,
  parameter int CW_INIT    = CW_INIT_DEF,
  parameter int LOCK_COUNT = 64
) (
  input logic          CLK,
  input logic          RESET,
  dpll_loop_filter_if.slave bus
);

  localparam int IW = CW_WIDTH + FRAC_BITS;
  localparam int RW = $clog2(LOCK_COUNT + 1);

  // One extra bit on the adders so overflow is visible before clamping.
  localparam logic [IW:0]          IMAX       = {1'b0, {IW{1'b1}}};
  localparam logic [IW:0]          KI_W       = (IW + 1)'(KI);
  localparam logic [CW_WIDTH:0]    CMAX       = {1'b0, {CW_WIDTH{1'b1}}};
  localparam logic [CW_WIDTH:0]    KP_W       = (CW_WIDTH + 1)'(KP);
  localparam logic [IW-1:0]        INTEG_INIT = IW'(CW_INIT) << FRAC_BITS;
  localparam logic [CW_WIDTH-1:0]  CTRL_INIT  = CW_WIDTH'(CW_INIT);
  localparam logic [RW-1:0]        REV_MAX    = RW'(LOCK_COUNT);

  // Index 0 = UP flag, index 1 = DOWN flag.
  logic [1:0] flag_in;
  logic [1:0] evt;

  assign flag_in = {bus.flagd, bus.flagu};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      dpll_flag_sync u_sync (
        .clk    (CLK),
        .rst    (RESET),
        .flag_i (flag_in[gi]),
        .evt_o  (evt[gi])
      );
    end
  endgenerate

  logic [IW-1:0]       integ_q,    integ_d;
  logic [CW_WIDTH-1:0] ctrl_q,     ctrl_d;
  logic                sat_q,      sat_d;
  logic                locked_q,   locked_d;
  lock_state_e         state_q,    state_d;
  dir_e                last_dir_q, last_dir_d;
  logic [RW-1:0]       rev_cnt_q,  rev_cnt_d;

  logic                act;
  logic                go_up;
  dir_e                evt_dir;
  logic [IW:0]         integ_ext;
  logic [IW:0]         integ_sum;
  logic [CW_WIDTH:0]   ip_ext;
  logic [CW_WIDTH:0]   ctrl_sum;

  always_comb begin
    // Simultaneous UP and DOWN cancel; HOLD discards any event.
    act       = (evt[0] ^ evt[1]) & ~bus.HOLD;
    go_up     = evt[0];
    evt_dir   = go_up ? UP : DN;

    // Integral path, clamped to the full integrator range.
    integ_ext = {1'b0, integ_q};
    integ_sum = '0;
    integ_d   = integ_q;
    if (act) begin
      if (go_up) begin
        integ_sum = integ_ext + KI_W;
        integ_d   = (integ_sum > IMAX) ? IMAX[IW-1:0] : integ_sum[IW-1:0];
      end else begin
        integ_sum = integ_ext - KI_W;
        integ_d   = (integ_ext < KI_W) ? '0 : integ_sum[IW-1:0];
      end
    end

    // Control word follows the updated integer part; the kick rides on top
    // only in the event cycle.
    ip_ext   = {1'b0, integ_d[IW-1:FRAC_BITS]};
    ctrl_sum = '0;
    ctrl_d   = ip_ext[CW_WIDTH-1:0];
    if (act) begin
      if (go_up) begin
        ctrl_sum = ip_ext + KP_W;
        ctrl_d   = (ctrl_sum > CMAX) ? CMAX[CW_WIDTH-1:0] : ctrl_sum[CW_WIDTH-1:0];
      end else begin
        ctrl_sum = ip_ext - KP_W;
        ctrl_d   = (ip_ext < KP_W) ? '0 : ctrl_sum[CW_WIDTH-1:0];
      end
    end

    sat_d = (integ_d == '0) || (integ_d == '1);

    // Lock detector: count alternating directions, any repeat drops lock.
    state_d    = state_q;
    last_dir_d = last_dir_q;
    rev_cnt_d  = rev_cnt_q;
    if (act) begin
      last_dir_d = evt_dir;
      if (last_dir_q == NONE) begin
        // First event after reset only establishes a reference direction.
      end else if (evt_dir != last_dir_q) begin
        if (rev_cnt_q != REV_MAX) begin
          rev_cnt_d = rev_cnt_q + 1'b1;
        end
        if (rev_cnt_d == REV_MAX) begin
          state_d = LOCKED;
        end
      end else begin
        rev_cnt_d = '0;
        state_d   = ACQ;
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      integ_q    <= INTEG_INIT;
      ctrl_q     <= CTRL_INIT;
      sat_q      <= 1'b0;
      locked_q   <= 1'b0;
      state_q    <= ACQ;
      last_dir_q <= NONE;
      rev_cnt_q  <= '0;
    end else begin
      integ_q    <= integ_d;
      ctrl_q     <= ctrl_d;
      sat_q      <= sat_d;
      locked_q   <= locked_d;
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      rev_cnt_q  <= rev_cnt_d;
    end
  end

  assign bus.ctrl   = ctrl_q;
  assign bus.locked = locked_q;
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Bench for dpll_loop_filter. Three instances share one stimulus stream:
//   0: defaults, 1: LOCK_COUNT=4, 2: CW_INIT=1020.
// The reference model schedules each flag rising edge to take effect two
// edges after the first edge that samples it, then applies the filter rules
// with plain integer arithmetic.
module tb_dpll_loop_filter;

  localparam int NI    = 3;
  localparam int P_CW  = 10;
  localparam int P_FB  = 4;
  localparam int P_KP  = 4;
  localparam int P_KI  = 1;
  localparam int P_INIT [NI] = '{512, 512, 1020};
  localparam int P_LOCK [NI] = '{64, 4, 64};

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic flagu_s = 1'b0;
  logic flagd_s = 1'b0;
  logic hold_s  = 1'b0;

  always #5 CLK = ~CLK;

  dpll_loop_filter_if #(.CW_WIDTH(P_CW)) if_def ();
  dpll_loop_filter_if #(.CW_WIDTH(P_CW)) if_lock ();
  dpll_loop_filter_if #(.CW_WIDTH(P_CW)) if_sat ();

  assign if_def.flagu  = flagu_s;
  assign if_def.flagd  = flagd_s;
  assign if_def.HOLD   = hold_s;
  assign if_lock.flagu = flagu_s;
  assign if_lock.flagd = flagd_s;
  assign if_lock.HOLD  = hold_s;
  assign if_sat.flagu  = flagu_s;
  assign if_sat.flagd  = flagd_s;
  assign if_sat.HOLD   = hold_s;

  dpll_loop_filter u_def (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if_def)
  );

  dpll_loop_filter #(.LOCK_COUNT(4)) u_lock (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if_lock)
  );

  dpll_loop_filter #(.CW_INIT(1020)) u_sat (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if_sat)
  );

  // ---------------- reference model ----------------
  int edge_n = 0;
  int sched_u[$];
  int sched_d[$];
  int m_integ  [NI];
  int m_ctrl   [NI];
  int m_sat    [NI];
  int m_locked [NI];
  int m_last   [NI];   // 0 none, 1 up, 2 down
  int m_rev    [NI];

  int n_pass   = 0;
  int n_checks = 0;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    sched_u.delete();
    sched_d.delete();
    for (int i = 0; i < NI; i++) begin
      m_integ[i]  = P_INIT[i] * (1 << P_FB);
      m_ctrl[i]   = P_INIT[i];
      m_sat[i]    = 0;
      m_locked[i] = 0;
      m_last[i]   = 0;
      m_rev[i]    = 0;
    end
  endtask

  task automatic model_step(input int i, input bit ev_u, input bit ev_d, input bit hold);
    int imax;
    int cmax;
    int dir;
    imax = (1 << (P_CW + P_FB)) - 1;
    cmax = (1 << P_CW) - 1;
    if ((ev_u != ev_d) && !hold) begin
      dir        = ev_u ? 1 : 2;
      m_integ[i] = clampi(m_integ[i] + (ev_u ? P_KI : -P_KI), 0, imax);
      m_ctrl[i]  = clampi((m_integ[i] >> P_FB) + (ev_u ? P_KP : -P_KP), 0, cmax);
      if (m_last[i] != 0) begin
        if (dir != m_last[i]) begin
          if (m_rev[i] < P_LOCK[i]) m_rev[i]++;
          if (m_rev[i] == P_LOCK[i]) m_locked[i] = 1;
        end else begin
          m_rev[i]    = 0;
          m_locked[i] = 0;
        end
      end
      m_last[i] = dir;
    end else begin
      m_ctrl[i] = m_integ[i] >> P_FB;
    end
    m_sat[i] = (m_integ[i] == 0 || m_integ[i] == imax) ? 1 : 0;
  endtask

  always @(posedge CLK or posedge RESET) begin
    bit ev_u;
    bit ev_d;
    if (RESET) begin
      model_reset();
    end else begin
      edge_n++;
      ev_u = 1'b0;
      ev_d = 1'b0;
      if (sched_u.size() > 0 && sched_u[0] == edge_n) begin
        ev_u = 1'b1;
        void'(sched_u.pop_front());
      end
      if (sched_d.size() > 0 && sched_d[0] == edge_n) begin
        ev_d = 1'b1;
        void'(sched_d.pop_front());
      end
      for (int i = 0; i < NI; i++) model_step(i, ev_u, ev_d, hold_s);
    end
  end

  // ---------------- checking ----------------
  function automatic logic [31:0] obs_ctrl(input int i);
    case (i)
      0:       return 32'(if_def.ctrl);
      1:       return 32'(if_lock.ctrl);
      default: return 32'(if_sat.ctrl);
    endcase
  endfunction

  function automatic logic [31:0] obs_locked(input int i);
    case (i)
      0:       return 32'(if_def.locked);
      1:       return 32'(if_lock.locked);
      default: return 32'(if_sat.locked);
    endcase
  endfunction

  function automatic logic [31:0] obs_sat(input int i);
    case (i)
      0:       return 32'(if_def.sat);
      1:       return 32'(if_lock.sat);
      default: return 32'(if_sat.sat);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    assert (obs === 32'(expv)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ctrl[%0d]", i),   obs_ctrl(i),   m_ctrl[i]);
      chk($sformatf("locked[%0d]", i), obs_locked(i), m_locked[i]);
      chk($sformatf("sat[%0d]", i),    obs_sat(i),    m_sat[i]);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then check at the
  // next falling edge.
  task automatic cyc(input bit u, input bit d, input bit h);
    if (u && !flagu_s) sched_u.push_back(edge_n + 3);
    if (d && !flagd_s) sched_d.push_back(edge_n + 3);
    flagu_s = u;
    flagd_s = d;
    hold_s  = h;
    @(negedge CLK);
    check_all();
  endtask

  task automatic pulse(input bit u, input bit d, input bit h, input int width, input int gap);
    for (int c = 0; c < width; c++) cyc(u, d, h);
    for (int c = 0; c < gap; c++) cyc(1'b0, 1'b0, h);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_all();
    RESET = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int saved;
    bit ru;
    bit rd;
    bit rh;

    // Reset state and idle behaviour.
    repeat (2) @(negedge CLK);
    check_all();
    chk("reset_ctrl", obs_ctrl(0), 512);
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0);
    chk("idle_ctrl", obs_ctrl(0), 512);

    // Single 3-wide UP pulse: kick visible for one cycle at k+2.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("kick_516", obs_ctrl(0), 516);
    cyc(1'b0, 1'b0, 1'b0);
    chk("after_kick_512", obs_ctrl(0), 512);
    cyc(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 15; p++) pulse(1'b1, 1'b0, 1'b0, 3, 3);
    chk("settle_513", obs_ctrl(0), 513);

    // Asynchronous reset in the middle of a low phase.
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_ctrl_def", obs_ctrl(0), 512);
    chk("async_ctrl_sat", obs_ctrl(2), 1020);
    chk("async_locked", obs_locked(1), 0);
    chk("async_sat", obs_sat(2), 0);
    @(negedge CLK);
    check_all();
    RESET = 1'b0;
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0);

    // Simultaneous UP and DOWN cancel.
    pulse(1'b1, 1'b1, 1'b0, 3, 3);
    chk("cancel_ctrl", obs_ctrl(0), 512);

    // Lock sequence on the LOCK_COUNT=4 instance.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 3, 3);
    pulse(1'b0, 1'b1, 1'b0, 3, 3);
    pulse(1'b1, 1'b0, 1'b0, 3, 3);
    pulse(1'b0, 1'b1, 1'b0, 3, 2);
    chk("pre_lock", obs_locked(1), 0);
    pulse(1'b1, 1'b0, 1'b0, 3, 0);
    chk("lock_set", obs_locked(1), 1);
    chk("lock_def_not", obs_locked(0), 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 3, 3);
    pulse(1'b1, 1'b0, 1'b0, 3, 3);
    chk("lock_drop", obs_locked(1), 0);

    // Saturation on the CW_INIT=1020 instance.
    do_reset();
    for (int p = 0; p < 66; p++) pulse(1'b1, 1'b0, 1'b0, 3, 2);
    chk("sat_ctrl_1023", obs_ctrl(2), 1023);
    chk("sat_flag", obs_sat(2), 1);
    pulse(1'b0, 1'b1, 1'b0, 3, 0);
    chk("sat_dn_kick", obs_ctrl(2), 1019);
    chk("sat_dn_flag", obs_sat(2), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sat_dn_settle", obs_ctrl(2), 1023);

    // Holdover: events discarded, then normal update resumes.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 3, 3);
    saved = m_ctrl[0];
    for (int p = 0; p < 5; p++) pulse(1'b1, 1'b0, 1'b1, 3, 2);
    chk("hold_frozen", obs_ctrl(0), saved);
    cyc(1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 3, 3);

    // Randomised phase against the model.
    for (int n = 0; n < 150; n++) begin
      ru = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ru && !rd) rd = 1'b1;
      rh = ($urandom_range(0, 7) == 0);
      pulse(ru, rd, rh, $urandom_range(2, 4), $urandom_range(1, 3));
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
